win_buff: RTL and testbench

Parametrised sliding-window buffer for the HOG front end. It accepts a raster pixel stream of one or more channels and keeps WIN_H-1 previous lines in line memories. For every accepted pixel it emits the WIN_W×WIN_H neighbourhood ending at that pixel, with a border flag and an end-of-frame flag. Line length and frame height are runtime-configurable, so one build serves several resolutions ahead of the gradient/histogram stages.

---
 rtl/win_buff_pkg.sv | 23 ++
 rtl/win_buff_if.sv | 37 +++
 rtl/win_buff_line_mem.sv | 22 ++
 rtl/win_buff.sv | 141 ++++++++++++++
 tb/tb_win_buff.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/win_buff_pkg.sv
// Shared helpers for the sliding-window buffer: sizing functions and the
// kernel element layout used by both the RTL and its consumers.
package win_buff_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

    // Bit offset of channel ch of window element (r,c); r=0 is the oldest line, c=0 the oldest column.
    function automatic int kern_off(input int r, input int c, input int ch,
                                    input int win_w, input int channels, input int pix_w);
        return (((r * win_w + c) * channels) + ch) * pix_w;
    endfunction

    function automatic int kern_width(input int win_w, input int win_h,
                                      input int channels, input int pix_w);
        return win_w * win_h * channels * pix_w;
    endfunction

endpackage

// File: rtl/win_buff_if.sv
// Pixel-in / kernel-out handshake bundle plus runtime frame geometry.
interface win_buff_if
    import win_buff_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int CHANNELS    = 1,
    parameter int MAX_LINE    = 640,
    parameter int MAX_ROWS    = 480,
    parameter int WIN_W       = 3,
    parameter int WIN_H       = 3
) ();
    localparam int PW = CHANNELS * PIXEL_WIDTH;
    localparam int KW = kern_width(WIN_W, WIN_H, CHANNELS, PIXEL_WIDTH);
    localparam int LW = clog2(MAX_LINE + 1);
    localparam int RW = clog2(MAX_ROWS + 1);

    logic [LW-1:0] cfg_line_len;
    logic [RW-1:0] cfg_rows;
    logic          p_valid;
    logic          p_ready;
    logic [PW-1:0] pixel;
    logic          k_valid;
    logic          k_ready;
    logic [KW-1:0] kernel;
    logic          k_border;
    logic          k_eof;

    modport slave (
        input  cfg_line_len, cfg_rows, p_valid, pixel, k_ready,
        output p_ready, k_valid, kernel, k_border, k_eof
    );

    modport master (
        output cfg_line_len, cfg_rows, p_valid, pixel, k_ready,
        input  p_ready, k_valid, kernel, k_border, k_eof
    );
endinterface

// File: rtl/win_buff_line_mem.sv
// One line of pixel history: single write port, asynchronous read.
module win_buff_line_mem
    import win_buff_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[addr] <= wdata;
    end

    assign rdata = mem_q[addr];
endmodule

// File: rtl/win_buff.sv
// Sliding-window buffer: chained line memories feed a WIN_H x WIN_W shift
// window; one registered kernel per accepted pixel once WIN_H-1 lines are filled.
module win_buff
    import win_buff_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int CHANNELS    = 1,
    parameter int MAX_LINE    = 640,
    parameter int MAX_ROWS    = 480,
    parameter int WIN_W       = 3,
    parameter int WIN_H       = 3
) (
    input  logic     clk,
    input  logic     rst,
    win_buff_if.slave bus
);
    localparam int PW = CHANNELS * PIXEL_WIDTH;
    localparam int KW = kern_width(WIN_W, WIN_H, CHANNELS, PIXEL_WIDTH);
    localparam int LW = clog2(MAX_LINE + 1);
    localparam int RW = clog2(MAX_ROWS + 1);
    localparam int AW = clog2(MAX_LINE);
    localparam int NL = WIN_H - 1;

    logic [LW-1:0] col_q, col_d, line_len_q, line_len_d;
    logic [RW-1:0] row_q, row_d, rows_q, rows_d;
    logic [WIN_H-1:0][WIN_W-1:0][PW-1:0] win_q, win_d;
    logic [KW-1:0] kernel_q, kernel_d;
    logic          k_valid_q, k_valid_d;
    logic          k_border_q, k_border_d;
    logic          k_eof_q, k_eof_d;
    logic [PW-1:0] lm_rd [NL];
    logic [PW-1:0] lm_wd [NL];
    logic          accept, produce, last_col, last_row;

    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] v);
        if (v < LW'(WIN_W))    return LW'(WIN_W);
        if (v > LW'(MAX_LINE)) return LW'(MAX_LINE);
        return v;
    endfunction

    function automatic logic [RW-1:0] clamp_rows(input logic [RW-1:0] v);
        if (v < RW'(WIN_H))    return RW'(WIN_H);
        if (v > RW'(MAX_ROWS)) return RW'(MAX_ROWS);
        return v;
    endfunction

    // Line 0 holds the previous row; each later line is fed by the one before it.
    for (genvar k = 0; k < NL; k++) begin : g_line
        if (k == 0) begin : g_head
            assign lm_wd[k] = bus.pixel;
        end else begin : g_tail
            assign lm_wd[k] = lm_rd[k-1];
        end
        win_buff_line_mem #(.DEPTH(MAX_LINE), .WIDTH(PW)) u_mem (
            .clk   (clk),
            .we    (accept),
            .addr  (col_q[AW-1:0]),
            .wdata (lm_wd[k]),
            .rdata (lm_rd[k])
        );
    end

    assign bus.p_ready  = !rst && (!k_valid_q || bus.k_ready);
    assign accept       = bus.p_valid && bus.p_ready;
    assign last_col     = (col_q == line_len_q - 1'b1);
    assign last_row     = (row_q == rows_q - 1'b1);
    assign produce      = (row_q >= RW'(WIN_H - 1));
    assign bus.k_valid  = k_valid_q;
    assign bus.kernel   = kernel_q;
    assign bus.k_border = k_border_q;
    assign bus.k_eof    = k_eof_q;

    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        line_len_d = line_len_q;
        rows_d     = rows_q;
        win_d      = win_q;
        kernel_d   = kernel_q;
        k_valid_d  = k_valid_q;
        k_border_d = k_border_q;
        k_eof_d    = k_eof_q;

        if (bus.k_ready) k_valid_d = 1'b0;

        // Geometry only changes between frames, on an idle cycle at the origin.
        if (!accept && col_q == '0 && row_q == '0) begin
            line_len_d = clamp_len(bus.cfg_line_len);
            rows_d     = clamp_rows(bus.cfg_rows);
        end

        if (accept) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            for (int r = 0; r < WIN_H; r++)
                for (int c = 0; c < WIN_W - 1; c++)
                    win_d[r][c] = win_q[r][c+1];
            for (int r = 0; r < WIN_H - 1; r++)
                win_d[r][WIN_W-1] = lm_rd[WIN_H-2-r];
            win_d[WIN_H-1][WIN_W-1] = bus.pixel;

            if (produce) begin
                k_valid_d  = 1'b1;
                k_border_d = (col_q < LW'(WIN_W - 1));
                k_eof_d    = last_col && last_row;
                for (int r = 0; r < WIN_H; r++)
                    for (int c = 0; c < WIN_W; c++)
                        kernel_d[kern_off(r, c, 0, WIN_W, CHANNELS, PIXEL_WIDTH) +: PW] = win_d[r][c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q      <= '0;
            row_q      <= '0;
            line_len_q <= clamp_len(bus.cfg_line_len);
            rows_q     <= clamp_rows(bus.cfg_rows);
            win_q      <= '0;
            kernel_q   <= '0;
            k_valid_q  <= 1'b0;
            k_border_q <= 1'b0;
            k_eof_q    <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            line_len_q <= line_len_d;
            rows_q     <= rows_d;
            win_q      <= win_d;
            kernel_q   <= kernel_d;
            k_valid_q  <= k_valid_d;
            k_border_q <= k_border_d;
            k_eof_q    <= k_eof_d;
        end
    end
endmodule

// File: tb/tb_win_buff.sv
// Bench for win_buff: single- and three-channel instances driven in lockstep and
// checked every cycle against a pixel-history reference model.
module tb_win_buff;
    localparam int ML = 16;
    localparam int MR = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    win_buff_if #(.PIXEL_WIDTH(8), .CHANNELS(1), .MAX_LINE(ML), .MAX_ROWS(MR), .WIN_W(3), .WIN_H(3)) if0 ();
    win_buff_if #(.PIXEL_WIDTH(8), .CHANNELS(3), .MAX_LINE(ML), .MAX_ROWS(MR), .WIN_W(3), .WIN_H(3)) if1 ();

    win_buff #(.PIXEL_WIDTH(8), .CHANNELS(1), .MAX_LINE(ML), .MAX_ROWS(MR), .WIN_W(3), .WIN_H(3))
        u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    win_buff #(.PIXEL_WIDTH(8), .CHANNELS(3), .MAX_LINE(ML), .MAX_ROWS(MR), .WIN_W(3), .WIN_H(3))
        u1 (.clk(clk), .rst(rst), .bus(if1.slave));

    int errors = 0;
    int checks = 0;

    // Reference state: h0/h1 = most recent / second most recent pixel seen at each column (-1 unknown).
    int h0 [ML];
    int h1 [ML];
    int m_win [3][3];
    int m_out [3][3];
    int mcol, mrow, mlen, mrows, cfg_len, cfg_rows;
    bit m_kv, m_bd, m_eof, last_acc;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    task automatic set_cfg(input int l, input int r);
        cfg_len  = l;
        cfg_rows = r;
        if0.cfg_line_len = 5'(l);
        if1.cfg_line_len = 5'(l);
        if0.cfg_rows     = 4'(r);
        if1.cfg_rows     = 4'(r);
    endtask

    task automatic chk_kernel(input string tag, input int vals [9]);
        logic [255:0] e0, o0;
        e0 = '0;
        for (int i = 0; i < 9; i++) e0[i*8 +: 8] = 8'(vals[i]);
        o0 = 256'(if0.kernel);
        chk(tag, o0, e0);
    endtask

    // One clock: drive, check against model, advance the model across the edge.
    task automatic cyc(input bit pv, input int idx, input bit kr, input bit rs);
        bit pr_exp, acc;
        int v, cv [3];
        logic [255:0] e0, m0, e1, m1, o0, o1;
        rst = rs;
        if0.p_valid = pv;   if1.p_valid = pv;
        if0.k_ready = kr;   if1.k_ready = kr;
        if0.pixel   = 8'(idx);
        if1.pixel   = {8'(idx + 200), 8'(idx + 100), 8'(idx)};
        #1;
        pr_exp = !rs && (!m_kv || kr);
        chk("p_ready", if0.p_ready, pr_exp);
        chk("p_ready_ch3", if1.p_ready, pr_exp);
        chk("k_valid", if0.k_valid, m_kv);
        chk("k_valid_ch3", if1.k_valid, m_kv);
        if (m_kv) begin
            e0 = '0; m0 = '0; e1 = '0; m1 = '0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) begin
                    v = m_out[r][c];
                    if (v >= 0) begin
                        e0[(r*3+c)*8 +: 8] = 8'(v);
                        m0[(r*3+c)*8 +: 8] = 8'hFF;
                        for (int ch = 0; ch < 3; ch++) begin
                            e1[((r*3+c)*3+ch)*8 +: 8] = 8'(v + 100*ch);
                            m1[((r*3+c)*3+ch)*8 +: 8] = 8'hFF;
                        end
                    end
                end
            o0 = 256'(if0.kernel);
            o1 = 256'(if1.kernel);
            chk("kernel", o0 & m0, e0);
            chk("kernel_ch3", o1 & m1, e1);
            chk("k_border", if0.k_border, m_bd);
            chk("k_eof", if0.k_eof, m_eof);
            chk("k_eof_ch3", if1.k_eof, m_eof);
        end
        acc = pv && pr_exp;
        last_acc = acc;
        @(posedge clk);
        if (rs) begin
            m_kv = 0; m_bd = 0; m_eof = 0; mcol = 0; mrow = 0;
            for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) m_win[r][c] = 0;
            mlen  = clampi(cfg_len, 3, ML);
            mrows = clampi(cfg_rows, 3, MR);
        end else begin
            if (!acc && mcol == 0 && mrow == 0) begin
                mlen  = clampi(cfg_len, 3, ML);
                mrows = clampi(cfg_rows, 3, MR);
            end
            if (acc) begin
                cv[0] = h1[mcol]; cv[1] = h0[mcol]; cv[2] = idx;
                h1[mcol] = h0[mcol];
                h0[mcol] = idx;
                for (int r = 0; r < 3; r++) begin
                    m_win[r][0] = m_win[r][1];
                    m_win[r][1] = m_win[r][2];
                    m_win[r][2] = cv[r];
                end
                if (mrow >= 2) begin
                    m_kv  = 1;
                    m_out = m_win;
                    m_bd  = (mcol < 2);
                    m_eof = (mcol == mlen - 1) && (mrow == mrows - 1);
                end else if (kr) m_kv = 0;
                if (mcol == mlen - 1) begin
                    mcol = 0;
                    mrow = (mrow == mrows - 1) ? 0 : mrow + 1;
                end else mcol++;
            end else if (kr) m_kv = 0;
        end
        @(negedge clk);
    endtask

    task automatic send(input int idx, input bit rnd, input bit rcfg);
        int n;
        bit pv, kr;
        n = 0;
        last_acc = 0;
        while (!last_acc && n < 200) begin
            pv = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            kr = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (rcfg) set_cfg($urandom_range(0, 20), $urandom_range(0, 12));
            cyc(pv, idx, kr, 1'b0);
            n++;
        end
        chk("accept_bound", last_acc, 1'b1);
    endtask

    int k20 [9] = '{0, 1, 2, 9, 10, 11, 18, 19, 20};
    int k48 [9] = '{36, 37, 38, 41, 42, 43, 46, 47, 48};

    initial begin
        for (int i = 0; i < ML; i++) begin h0[i] = -1; h1[i] = -1; end
        for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) begin m_win[r][c] = 0; m_out[r][c] = 0; end
        mcol = 0; mrow = 0; m_kv = 0; m_bd = 0; m_eof = 0; last_acc = 0;
        set_cfg(9, 4);
        mlen = 9; mrows = 4;
        if0.p_valid = 0; if1.p_valid = 0; if0.k_ready = 1; if1.k_ready = 1;
        if0.pixel = '0; if1.pixel = '0;
        @(negedge clk);

        // Reset state
        cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 1);
        chk("rst_kernel", if0.kernel, 0);
        chk("rst_kernel_ch3", if1.kernel, 0);
        chk("rst_border", if0.k_border, 0);
        chk("rst_eof", if0.k_eof, 0);
        cyc(0, 0, 1, 0);

        // Frame 1: 9x4, gap-free
        for (int i = 0; i < 36; i++) begin
            send(i, 0, 0);
            if (i == 17) chk("fill_px17", if0.k_valid, 0);
            if (i == 18) begin chk("px18_valid", if0.k_valid, 1); chk("px18_border", if0.k_border, 1); end
            if (i == 20) begin chk_kernel("px20_kernel", k20); chk("px20_border", if0.k_border, 0); end
            if (i == 35) chk("px35_eof", if0.k_eof, 1);
        end
        cyc(0, 0, 1, 0);

        // Frame 2: backpressure on pixel 22's kernel
        for (int i = 0; i < 36; i++) begin
            send(i, 0, 0);
            if (i == 22) begin
                repeat (3) begin
                    cyc(1, 23, 0, 0);
                    chk("stall_p_ready", if0.p_ready, 0);
                    chk("stall_k_valid", if0.k_valid, 1);
                end
            end
        end
        cyc(0, 0, 1, 0);

        // Frame 3: random bubbles and backpressure
        for (int i = 0; i < 36; i++) send(i, 1, 0);
        cyc(0, 0, 1, 0);

        // Frame 4: shorter lines latched at frame start
        set_cfg(5, 4);
        cyc(0, 0, 1, 0);
        for (int i = 36; i < 56; i++) begin
            send(i, 0, 0);
            if (i == 45) chk("short_fill", if0.k_valid, 0);
            if (i == 48) chk_kernel("px48_kernel", k48);
            if (i == 55) chk("short_eof", if0.k_eof, 1);
        end

        // Reset mid-frame
        set_cfg(9, 4);
        cyc(0, 0, 1, 0);
        for (int i = 0; i < 26; i++) send(60 + i, 0, 0);
        cyc(0, 0, 1, 1);
        chk("midrst_k_valid", if0.k_valid, 0);
        for (int j = 0; j < 18; j++) begin
            send(100 + j, 0, 0);
            chk("post_rst_fill", if0.k_valid, 0);
        end
        send(118, 0, 0);
        chk("post_rst_valid", if0.k_valid, 1);
        chk("post_rst_border", if0.k_border, 1);

        // Random geometry (including clamped values), bubbles and backpressure
        cyc(0, 0, 1, 0);
        for (int i = 0; i < 300; i++) send(200 + i, 1, 1);
        cyc(0, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
